// File: rtl/step_sequencer.sv
// Hardwired control sequencer: fetch/execute T-state FSM with Moore strobe decode.
// Optional SEQ_MEM_WAIT_EN: memory states stall on mem_rdy_i with a timeout into HALT.
// state | meaning
// IDLE  | waiting for run
// T0-T2 | fetch (opcode latched leaving T2)
// T3-T7 | execute, length depends on opcode
// HALT  | stopped by halt or memory timeout, left only by clear
module step_sequencer #(
   parameter int OP_W  = 5,
   parameter int TMO_W = 4
) (
   input  logic            clock_i,
   input  logic            clear_i,
   input  logic            run_i,
   input  logic [OP_W-1:0] opcode_i,
   input  logic            mem_rdy_i,
   output logic [18:0]     ctrl_o,
   output logic [OP_W-1:0] alu_op_o,
   output logic [3:0]      step_o,
   output logic            illegal_o,
   output logic            mem_err_o
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_T7   = 4'd8,
      S_HALT = 4'd15
   } state_t;

   localparam logic [OP_W-1:0] OP_LD   = OP_W'(0);
   localparam logic [OP_W-1:0] OP_LDI  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ST   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(6);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(12);
   localparam logic [OP_W-1:0] OP_HALT = OP_W'(27);
   localparam logic [OP_W-1:0] ALU_ADD = OP_W'(3);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2**TMO_W) - 2);

   localparam int C_PCOUT   = 0;
   localparam int C_MARIN   = 1;
   localparam int C_INCPC   = 2;
   localparam int C_ZIN     = 3;
   localparam int C_ZLOWOUT = 4;
   localparam int C_PCIN    = 5;
   localparam int C_READ    = 6;
   localparam int C_WRITE   = 7;
   localparam int C_MDRIN   = 8;
   localparam int C_MDROUT  = 9;
   localparam int C_IRIN    = 10;
   localparam int C_GRA     = 11;
   localparam int C_GRB     = 12;
   localparam int C_GRC     = 13;
   localparam int C_RIN     = 14;
   localparam int C_ROUT    = 15;
   localparam int C_BAOUT   = 16;
   localparam int C_COUT    = 17;
   localparam int C_YIN     = 18;

   state_t            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              err_q, err_d;
   logic [18:0]       ctrl_q;
   logic [OP_W-1:0]   alu_q;
   logic              ill_q;
   logic              mem_state;
   logic              mem_ok;
   logic              mem_tmo;

   function automatic logic is_mem_op(input logic [OP_W-1:0] op);
      return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
   endfunction

   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

   function automatic logic is_legal(input logic [OP_W-1:0] op);
      return is_mem_op(op) || is_arith(op) || (op == OP_ADDI);
   endfunction

   function automatic logic [18:0] ctrl_dec(input state_t s, input logic [OP_W-1:0] op);
      logic [18:0] c;
      c = '0;
      case (s)
         S_T0: begin
            c[C_PCOUT] = 1'b1; c[C_MARIN] = 1'b1; c[C_INCPC] = 1'b1; c[C_ZIN] = 1'b1;
         end
         S_T1: begin
            c[C_ZLOWOUT] = 1'b1; c[C_PCIN] = 1'b1; c[C_READ] = 1'b1; c[C_MDRIN] = 1'b1;
         end
         S_T2: begin
            c[C_MDROUT] = 1'b1; c[C_IRIN] = 1'b1;
         end
         S_T3: begin
            if (is_mem_op(op)) begin
               c[C_GRB] = 1'b1; c[C_BAOUT] = 1'b1; c[C_YIN] = 1'b1;
            end else if (is_arith(op) || op == OP_ADDI) begin
               c[C_GRB] = 1'b1; c[C_ROUT] = 1'b1; c[C_YIN] = 1'b1;
            end
         end
         S_T4: begin
            c[C_ZIN] = 1'b1;
            if (is_arith(op)) begin
               c[C_GRC] = 1'b1; c[C_ROUT] = 1'b1;
            end else begin
               c[C_COUT] = 1'b1;
            end
         end
         S_T5: begin
            c[C_ZLOWOUT] = 1'b1;
            if (op == OP_LD || op == OP_ST) begin
               c[C_MARIN] = 1'b1;
            end else begin
               c[C_GRA] = 1'b1; c[C_RIN] = 1'b1;
            end
         end
         S_T6: begin
            c[C_MDRIN] = 1'b1;
            if (op == OP_ST) begin
               c[C_GRA] = 1'b1; c[C_ROUT] = 1'b1;
            end else begin
               c[C_READ] = 1'b1;
            end
         end
         S_T7: begin
            if (op == OP_ST) begin
               c[C_WRITE] = 1'b1;
            end else begin
               c[C_MDROUT] = 1'b1; c[C_GRA] = 1'b1; c[C_RIN] = 1'b1;
            end
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [OP_W-1:0] alu_dec(input state_t s, input logic [OP_W-1:0] op);
      if (s != S_T4) return '0;
      if (is_arith(op)) return op;
      return ALU_ADD;
   endfunction

   assign mem_state = (state_q == S_T1)
                    || (state_q == S_T6 && op_q == OP_LD)
                    || (state_q == S_T7 && op_q == OP_ST);

`ifdef SEQ_MEM_WAIT_EN
   assign mem_ok    = mem_rdy_i;
   assign mem_tmo   = !mem_rdy_i && (tmo_q == TMO_LAST);
   assign mem_err_o = err_q;
`else
   logic unused_mem_rdy;
   assign unused_mem_rdy = mem_rdy_i;
   assign mem_ok    = 1'b1;
   assign mem_tmo   = 1'b0;
   assign mem_err_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: if (run_i) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2: begin
            op_d    = opcode_i;
            state_d = (opcode_i == OP_HALT) ? S_HALT : S_T3;
         end
         S_T3:   state_d = is_legal(op_q) ? S_T4 : (run_i ? S_T0 : S_IDLE);
         S_T4:   state_d = S_T5;
         S_T5: begin
            if (op_q == OP_LD || op_q == OP_ST) state_d = S_T6;
            else                                state_d = run_i ? S_T0 : S_IDLE;
         end
         S_T6:   state_d = S_T7;
         S_T7:   state_d = run_i ? S_T0 : S_IDLE;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      // A memory state only advances once the access completes; otherwise it stalls or times out.
      if (mem_state) begin
         if (mem_ok) begin
            tmo_d = '0;
         end else if (mem_tmo) begin
            state_d = S_HALT;
            err_d   = 1'b1;
            tmo_d   = '0;
         end else begin
            state_d = state_q;
            tmo_d   = tmo_q + TMO_W'(1);
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (clear_i) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         ctrl_q  <= '0;
         alu_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         ctrl_q  <= ctrl_dec(state_d, op_d);
         alu_q   <= alu_dec(state_d, op_d);
         ill_q   <= (state_d == S_T3) && !is_legal(op_d);
      end
   end

   assign ctrl_o    = ctrl_q;
   assign alu_op_o  = alu_q;
   assign step_o    = state_q;
   assign illegal_o = ill_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: per-cycle expected step/strobes queued per instruction.
module tb_step_sequencer;

   localparam logic [18:0] PCOUT   = 19'h1 << 0;
   localparam logic [18:0] MARIN   = 19'h1 << 1;
   localparam logic [18:0] INCPC   = 19'h1 << 2;
   localparam logic [18:0] ZIN     = 19'h1 << 3;
   localparam logic [18:0] ZLOWOUT = 19'h1 << 4;
   localparam logic [18:0] PCIN    = 19'h1 << 5;
   localparam logic [18:0] READ    = 19'h1 << 6;
   localparam logic [18:0] WRITE   = 19'h1 << 7;
   localparam logic [18:0] MDRIN   = 19'h1 << 8;
   localparam logic [18:0] MDROUT  = 19'h1 << 9;
   localparam logic [18:0] IRIN    = 19'h1 << 10;
   localparam logic [18:0] GRA     = 19'h1 << 11;
   localparam logic [18:0] GRB     = 19'h1 << 12;
   localparam logic [18:0] GRC     = 19'h1 << 13;
   localparam logic [18:0] RIN     = 19'h1 << 14;
   localparam logic [18:0] ROUT    = 19'h1 << 15;
   localparam logic [18:0] BAOUT   = 19'h1 << 16;
   localparam logic [18:0] COUT    = 19'h1 << 17;
   localparam logic [18:0] YIN     = 19'h1 << 18;

   typedef struct packed {
      logic [3:0]  step;
      logic [18:0] ctrl;
      logic [4:0]  alu;
      logic        ill;
      logic        err;
   } exp_t;

   logic        clock;
   logic        clear;
   logic        run;
   logic [4:0]  opcode;
   logic        mem_rdy;
   logic [18:0] ctrl;
   logic [4:0]  alu_op;
   logic [3:0]  step;
   logic        illegal;
   logic        mem_err;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   step_sequencer #(.OP_W(5), .TMO_W(4)) dut (
      .clock_i   (clock),
      .clear_i   (clear),
      .run_i     (run),
      .opcode_i  (opcode),
      .mem_rdy_i (mem_rdy),
      .ctrl_o    (ctrl),
      .alu_op_o  (alu_op),
      .step_o    (step),
      .illegal_o (illegal),
      .mem_err_o (mem_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, want);
      end
   endtask

   task automatic push(input logic [3:0] s, input logic [18:0] c, input logic [4:0] a,
                       input logic il, input logic er);
      exp_t e;
      e.step = s; e.ctrl = c; e.alu = a; e.ill = il; e.err = er;
      exp_q.push_back(e);
   endtask

   task automatic push_instr(input logic [4:0] op);
      push(4'd1, PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'b0, 1'b0);
      push(4'd2, ZLOWOUT | PCIN | READ | MDRIN, 5'd0, 1'b0, 1'b0);
      push(4'd3, MDROUT | IRIN, 5'd0, 1'b0, 1'b0);
      case (op)
         5'd0, 5'd1, 5'd2: begin
            push(4'd4, GRB | BAOUT | YIN, 5'd0, 1'b0, 1'b0);
            push(4'd5, COUT | ZIN, 5'd3, 1'b0, 1'b0);
            if (op == 5'd1) begin
               push(4'd6, ZLOWOUT | GRA | RIN, 5'd0, 1'b0, 1'b0);
            end else begin
               push(4'd6, ZLOWOUT | MARIN, 5'd0, 1'b0, 1'b0);
               if (op == 5'd0) begin
                  push(4'd7, READ | MDRIN, 5'd0, 1'b0, 1'b0);
                  push(4'd8, MDROUT | GRA | RIN, 5'd0, 1'b0, 1'b0);
               end else begin
                  push(4'd7, GRA | ROUT | MDRIN, 5'd0, 1'b0, 1'b0);
                  push(4'd8, WRITE, 5'd0, 1'b0, 1'b0);
               end
            end
         end
         5'd3, 5'd4, 5'd5, 5'd6: begin
            push(4'd4, GRB | ROUT | YIN, 5'd0, 1'b0, 1'b0);
            push(4'd5, GRC | ROUT | ZIN, op, 1'b0, 1'b0);
            push(4'd6, ZLOWOUT | GRA | RIN, 5'd0, 1'b0, 1'b0);
         end
         5'd12: begin
            push(4'd4, GRB | ROUT | YIN, 5'd0, 1'b0, 1'b0);
            push(4'd5, COUT | ZIN, 5'd3, 1'b0, 1'b0);
            push(4'd6, ZLOWOUT | GRA | RIN, 5'd0, 1'b0, 1'b0);
         end
         5'd27: ;
         default: push(4'd4, 19'd0, 5'd0, 1'b1, 1'b0);
      endcase
   endtask

   task automatic check_n(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         if (exp_q.size() == 0) begin
            chk("queue_underrun", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("step", {28'd0, step}, {28'd0, e.step});
            chk("ctrl", {13'd0, ctrl}, {13'd0, e.ctrl});
            chk("alu_op", {27'd0, alu_op}, {27'd0, e.alu});
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
         end
`ifndef SEQ_MEM_WAIT_EN
         mem_rdy = 1'($urandom_range(0, 1));
`endif
      end
   endtask

   task automatic check_all();
      check_n(exp_q.size());
   endtask

   logic [4:0] ops[9] = '{5'd2, 5'd0, 5'd4, 5'd12, 5'd1, 5'd3, 5'd5, 5'd6, 5'd9};

   initial begin
      clear = 1'b1; run = 1'b0; opcode = 5'd0; mem_rdy = 1'b1;
      push(4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
      push(4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
      check_all();

      clear = 1'b0; run = 1'b1;
      foreach (ops[k]) begin
         push_instr(ops[k]);
         opcode = ops[k];
         check_all();
      end

      // run dropped during T4 of add: instruction completes, then idle
      push_instr(5'd3);
      opcode = 5'd3;
      check_n(5);
      run = 1'b0;
      check_n(1);
      push(4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
      push(4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
      check_all();

      // clear during T6 of ld
      run = 1'b1;
      push_instr(5'd0);
      void'(exp_q.pop_back());
      opcode = 5'd0;
      check_all();
      clear = 1'b1;
      push(4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
      check_all();
      clear = 1'b0; run = 1'b0;
      push(4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
      check_all();

      // halt holds until clear
      run = 1'b1;
      push_instr(5'd27);
      opcode = 5'd27;
      for (int i = 0; i < 20; i++) push(4'd15, 19'd0, 5'd0, 1'b0, 1'b0);
      check_all();
      clear = 1'b1; run = 1'b0;
      push(4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
      check_all();
      clear = 1'b0;
      push(4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
      check_all();

`ifdef SEQ_MEM_WAIT_EN
      // T1 stalls three cycles on mem_rdy low
      run = 1'b1; opcode = 5'd1; mem_rdy = 1'b1;
      push_instr(5'd1);
      for (int i = 0; i < 3; i++) exp_q.insert(1, exp_q[1]);
      check_n(1);
      mem_rdy = 1'b0;
      check_n(4);
      mem_rdy = 1'b1;
      run = 1'b0;
      push(4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
      check_all();

      // timeout: 15 cycles in T1 without mem_rdy, then HALT with mem_err
      run = 1'b1; mem_rdy = 1'b0;
      push_instr(5'd1);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      for (int i = 0; i < 14; i++) exp_q.push_back(exp_q[1]);
      for (int i = 0; i < 3; i++) push(4'd15, 19'd0, 5'd0, 1'b0, 1'b1);
      check_all();
      clear = 1'b1; run = 1'b0; mem_rdy = 1'b1;
      push(4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
      check_all();
      clear = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
